// File: rtl/pakout_if.sv
// Bundle of per-channel packet outputs and 4-phase handshake lines for pakout_gen.
// Every flattened bus uses the same slicing: channel k sits at [k*W +: W].
interface pakout_if #(
  parameter int NCH = 2,
  parameter int ASZ = 6,
  parameter int DSZ = 8,
  parameter int RSZ = 4,
  parameter int CSZ = 16
);
  logic [NCH-1:0]     o_req;
  logic [NCH-1:0]     i_ack;
  logic [NCH*ASZ-1:0] o_src;
  logic [NCH*ASZ-1:0] o_dst;
  logic [NCH*DSZ-1:0] o_dat;
  logic [NCH*RSZ-1:0] o_red;
  logic [NCH-1:0]     o_busy;
  logic [NCH-1:0]     o_done;
  logic [NCH*CSZ-1:0] o_sent;

  modport master (
    output o_req, o_src, o_dst, o_dat, o_red, o_busy, o_done, o_sent,
    input  i_ack
  );

  modport slave (
    input  o_req, o_src, o_dst, o_dat, o_red, o_busy, o_done, o_sent,
    output i_ack
  );
endinterface

// File: rtl/pakout_gen.sv
// Multi-channel packet source for NoC debug benches. Each channel loads a
// packet (src/dst/dat/red), offers it on a 4-phase req/ack handshake and
// counts completions. Channels share only the clock, reset and enable.
//
// state | meaning
// IDLE  | no packet held; loads the next one when enabled and not done
// ARM   | packet loaded, waiting for ack low before raising req
// REQ   | req high, waiting for ack
// REL   | req dropped, waiting for ack to return low
module pakout_gen #(
  parameter int NCH      = 2,
  parameter int MIN_ADDR = 1,
  parameter int MAX_ADDR = 3,
  parameter int ASZ      = 6,
  parameter int DSZ      = 8,
  parameter int RSZ      = 4,
  parameter int SRC_BASE = 3,
  parameter int INIT_DAT = 5,
  parameter int NPKT     = 0,
  parameter int CSZ      = 16
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_en,
  pakout_if.master bus
);

  typedef enum logic [1:0] {IDLE, ARM, REQ, REL} state_t;

  localparam logic [ASZ-1:0] MIN_A  = ASZ'(MIN_ADDR);
  localparam logic [ASZ-1:0] MAX_A  = ASZ'(MAX_ADDR);
  localparam logic [CSZ-1:0] NPKT_C = CSZ'(NPKT);

  genvar k;
  generate
    for (k = 0; k < NCH; k++) begin : g_ch
      localparam logic [ASZ-1:0] SRC_K = ASZ'(SRC_BASE + k);
      localparam logic [DSZ-1:0] DAT_K = DSZ'(INIT_DAT + k);

      state_t         st_q, st_d;
      logic           req_q, req_d;
      logic           busy_q, busy_d;
      logic           done_q, done_d;
      logic [CSZ-1:0] sent_q, sent_d;
      logic [ASZ-1:0] dst_q, dst_d;
      logic [DSZ-1:0] dat_q, dat_d;
      logic [RSZ-1:0] red_q, red_d;
      logic [ASZ-1:0] nxt_q, nxt_d;
      logic [DSZ-1:0] cnt_q, cnt_d;
      logic           ack;

      assign ack = bus.i_ack[k];

      // Next-state and next-field logic; every register holds by default.
      always_comb begin
        st_d   = st_q;
        req_d  = req_q;
        busy_d = busy_q;
        done_d = done_q;
        sent_d = sent_q;
        dst_d  = dst_q;
        dat_d  = dat_q;
        red_d  = red_q;
        nxt_d  = nxt_q;
        cnt_d  = cnt_q;
        case (st_q)
          IDLE: begin
            if (i_en && !done_q) begin
              dst_d  = nxt_q;
              dat_d  = cnt_q;
              // The three-term sum never exceeds max(ASZ,DSZ)+2 bits, so its
              // low RSZ bits equal the sum of the operands taken mod 2^RSZ.
              red_d  = RSZ'(SRC_K) + RSZ'(nxt_q) + RSZ'(cnt_q);
              cnt_d  = cnt_q + 1'b1;
              nxt_d  = (nxt_q >= MAX_A) ? MIN_A : nxt_q + 1'b1;
              busy_d = 1'b1;
              st_d   = ARM;
            end
          end
          ARM: begin
            if (!ack) begin
              req_d = 1'b1;
              st_d  = REQ;
            end
          end
          REQ: begin
            if (ack) begin
              req_d  = 1'b0;
              sent_d = (&sent_q) ? sent_q : sent_q + 1'b1;
              st_d   = REL;
            end
          end
          REL: begin
            if (!ack) begin
              busy_d = 1'b0;
              st_d   = IDLE;
              if ((NPKT != 0) && (sent_q == NPKT_C)) done_d = 1'b1;
            end
          end
          default: st_d = IDLE;
        endcase
      end

      // Channel state register; reset drops req immediately.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          st_q   <= IDLE;
          req_q  <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          sent_q <= '0;
          dst_q  <= MIN_A;
          dat_q  <= DAT_K;
          red_q  <= '0;
          nxt_q  <= MIN_A;
          cnt_q  <= DAT_K;
        end else begin
          st_q   <= st_d;
          req_q  <= req_d;
          busy_q <= busy_d;
          done_q <= done_d;
          sent_q <= sent_d;
          dst_q  <= dst_d;
          dat_q  <= dat_d;
          red_q  <= red_d;
          nxt_q  <= nxt_d;
          cnt_q  <= cnt_d;
        end
      end

      assign bus.o_req[k]              = req_q;
      assign bus.o_busy[k]             = busy_q;
      assign bus.o_done[k]             = done_q;
      assign bus.o_src[k*ASZ +: ASZ]   = SRC_K;
      assign bus.o_dst[k*ASZ +: ASZ]   = dst_q;
      assign bus.o_dat[k*DSZ +: DSZ]   = dat_q;
      assign bus.o_red[k*RSZ +: RSZ]   = red_q;
      assign bus.o_sent[k*CSZ +: CSZ]  = sent_q;
    end
  endgenerate

endmodule

// File: tb/tb_pakout_gen.sv
// Bench for pakout_gen: a 2-channel default instance (A) and a 1-channel
// instance (B) with constant dst, 4-bit data and a 3-packet limit.
// Logical channels 0,1 map to A, channel 2 maps to B.
module tb_pakout_gen;

  typedef struct packed {
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] dat;
    logic [7:0] red;
  } pkt_t;

  logic clk;
  logic rst_a, rst_b, en_a, en_b;
  logic [2:0] ack_all;

  pakout_if #(.NCH(2)) ifa ();
  pakout_if #(.NCH(1), .DSZ(4)) ifb ();

  assign ifa.i_ack = ack_all[1:0];
  assign ifb.i_ack = ack_all[2:2];

  pakout_gen #(.NCH(2)) dut_a (
    .i_clk(clk), .i_rst_n(rst_a), .i_en(en_a), .bus(ifa)
  );

  pakout_gen #(.NCH(1), .MIN_ADDR(2), .MAX_ADDR(2), .DSZ(4), .INIT_DAT(14), .NPKT(3)) dut_b (
    .i_clk(clk), .i_rst_n(rst_b), .i_en(en_b), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unified per-channel views of both instances
  logic [2:0] req_v, busy_v, done_v;
  logic [7:0] src_v [3];
  logic [7:0] dst_v [3];
  logic [7:0] dat_v [3];
  logic [7:0] red_v [3];
  logic [15:0] sent_v [3];

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      req_v[c]  = ifa.o_req[c];
      busy_v[c] = ifa.o_busy[c];
      done_v[c] = ifa.o_done[c];
      src_v[c]  = {2'b00, ifa.o_src[c*6 +: 6]};
      dst_v[c]  = {2'b00, ifa.o_dst[c*6 +: 6]};
      dat_v[c]  = ifa.o_dat[c*8 +: 8];
      red_v[c]  = {4'b0000, ifa.o_red[c*4 +: 4]};
      sent_v[c] = ifa.o_sent[c*16 +: 16];
    end
    req_v[2]  = ifb.o_req[0];
    busy_v[2] = ifb.o_busy[0];
    done_v[2] = ifb.o_done[0];
    src_v[2]  = {2'b00, ifb.o_src};
    dst_v[2]  = {2'b00, ifb.o_dst};
    dat_v[2]  = {4'b0000, ifb.o_dat};
    red_v[2]  = {4'b0000, ifb.o_red};
    sent_v[2] = ifb.o_sent;
  end

  // Per-channel configuration
  function automatic int c_src(int c);  return (c == 1) ? 4 : 3;                 endfunction
  function automatic int c_init(int c); return (c == 0) ? 5 : (c == 1) ? 6 : 14; endfunction
  function automatic int c_dmod(int c); return (c == 2) ? 16 : 256;              endfunction
  function automatic int c_min(int c);  return (c == 2) ? 2 : 1;                 endfunction
  function automatic int c_max(int c);  return (c == 2) ? 2 : 3;                 endfunction
  function automatic int c_npkt(int c); return (c == 2) ? 3 : 0;                 endfunction

  // Reference: the n-th packet of channel c, straight from the field rules
  function automatic pkt_t model_pkt(int c, int n);
    pkt_t p;
    int span, s, d, x;
    span = c_max(c) - c_min(c) + 1;
    s = c_src(c);
    d = c_min(c) + (n % span);
    x = (c_init(c) + n) % c_dmod(c);
    p.src = 8'(s);
    p.dst = 8'(d);
    p.dat = 8'(x);
    p.red = 8'((s + d + x) % 16);
    return p;
  endfunction

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int c, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s ch%0d: got %0d expected %0d", name, c, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int c);
    tests++;
    fails++;
    $display("FAIL %s ch%0d: got timeout/unexpected expected event", name, c);
  endtask

  pkt_t exp_q [3][$];
  int   nxt_idx [3];
  int   ack_cnt [3];
  int   dly     [3];
  bit   in_pkt  [3];
  bit   resp_on [3];
  bit   mon_on  [3];
  int   seen    [3];

  function automatic int new_dly(int c);
    return (c == 1) ? 2 + 2 * int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
  endfunction

  task automatic push_next(input int c);
    if (c_npkt(c) == 0 || nxt_idx[c] < c_npkt(c)) begin
      exp_q[c].push_back(model_pkt(c, nxt_idx[c]));
      nxt_idx[c]++;
    end
  endtask

  // Ack responders: raise ack some cycles after req, drop it some cycles after req falls
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 3; c++) begin
        if (resp_on[c]) begin
          if (req_v[c] && !ack_all[c]) begin
            if (dly[c] > 0) dly[c]--;
            else begin
              ack_all[c] = 1'b1;
              ack_cnt[c]++;
              in_pkt[c] = 1'b1;
              dly[c] = new_dly(c);
            end
          end else if (!req_v[c] && ack_all[c]) begin
            if (dly[c] > 0) dly[c]--;
            else begin
              ack_all[c] = 1'b0;
              dly[c] = new_dly(c);
              if (in_pkt[c]) push_next(c);
              in_pkt[c] = 1'b0;
            end
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every req rise and checks handshake timing
  int cyc = 0;
  logic [2:0] p_req = '0, p_busy = '0, p_ack = '0, p_done = '0;
  logic [7:0] p_dst [3];
  logic [7:0] p_dat [3];
  logic [7:0] p_red [3];
  int t_busy_rise [3];
  int t_ack_rise  [3];
  int t_ack_fall  [3];

  initial begin
    pkt_t e;
    int base;
    for (int c = 0; c < 3; c++) begin
      t_busy_rise[c] = 0; t_ack_rise[c] = 0; t_ack_fall[c] = 0;
      p_dst[c] = '0; p_dat[c] = '0; p_red[c] = '0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int c = 0; c < 3; c++) begin
        if (ack_all[c] && !p_ack[c]) t_ack_rise[c] = cyc;
        if (!ack_all[c] && p_ack[c]) t_ack_fall[c] = cyc;
        if (busy_v[c] && !p_busy[c]) t_busy_rise[c] = cyc;
        if (mon_on[c]) begin
          if (busy_v[c] && p_busy[c])
            check("fields_hold", c, {dst_v[c], dat_v[c], red_v[c]}, {p_dst[c], p_dat[c], p_red[c]});
          if (req_v[c] && !p_req[c]) begin
            seen[c]++;
            if (exp_q[c].size() == 0) fail_now("unexpected_req", c);
            else begin
              e = exp_q[c].pop_front();
              check("src", c, src_v[c], e.src);
              check("dst", c, dst_v[c], e.dst);
              check("dat", c, dat_v[c], e.dat);
              check("red", c, red_v[c], e.red);
              base = (t_busy_rise[c] > t_ack_fall[c]) ? t_busy_rise[c] : t_ack_fall[c];
              check("req_rise_lat", c, cyc, base + 1);
            end
          end
          if (!req_v[c] && p_req[c]) begin
            check("req_fall_lat", c, cyc, t_ack_rise[c] + 1);
            check("sent", c, sent_v[c], ack_cnt[c]);
          end
          if (!busy_v[c] && p_busy[c]) begin
            check("busy_fall_lat", c, cyc, t_ack_fall[c] + 1);
            check("done", c, done_v[c], (c_npkt(c) != 0 && ack_cnt[c] == c_npkt(c)) ? 1 : 0);
          end
          if (p_done[c]) check("done_sticky", c, done_v[c], 1);
        end
        p_req[c] = req_v[c]; p_busy[c] = busy_v[c]; p_ack[c] = ack_all[c]; p_done[c] = done_v[c];
        p_dst[c] = dst_v[c]; p_dat[c] = dat_v[c]; p_red[c] = red_v[c];
      end
    end
  end

  task automatic wait_seen(input int c, input int target, input int budget);
    int n = 0;
    while (seen[c] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (seen[c] < target) fail_now("wait_packets", c);
  endtask

  task automatic wait_req(input int c, input int budget);
    int n = 0;
    @(negedge clk);
    while (!req_v[c] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!req_v[c]) fail_now("wait_req", c);
  endtask

  initial begin
    int n;
    int s0;
    rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
    ack_all = 3'b100;  // B starts with a stuck-high ack
    for (int c = 0; c < 3; c++) begin
      nxt_idx[c] = 0; ack_cnt[c] = 0; dly[c] = 0; in_pkt[c] = 1'b0;
      resp_on[c] = 1'b0; mon_on[c] = 1'b0; seen[c] = 0;
    end

    // Reset values
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      check("rst_req", c, req_v[c], 0);
      check("rst_busy", c, busy_v[c], 0);
      check("rst_done", c, done_v[c], 0);
      check("rst_sent", c, sent_v[c], 0);
      check("rst_src", c, src_v[c], c_src(c));
      check("rst_dst", c, dst_v[c], c_min(c));
      check("rst_dat", c, dat_v[c], c_init(c));
      check("rst_red", c, red_v[c], 0);
    end

    for (int c = 0; c < 3; c++) push_next(c);
    en_a = 1'b1; en_b = 1'b1;
    resp_on[0] = 1'b1; resp_on[1] = 1'b1;
    mon_on[0] = 1'b1; mon_on[1] = 1'b1; mon_on[2] = 1'b1;
    #2;
    rst_a = 1'b1; rst_b = 1'b1;

    // Stuck ack on B: packet loaded, req held low
    repeat (6) @(negedge clk);
    check("stuck_busy", 2, busy_v[2], 1);
    check("stuck_req", 2, req_v[2], 0);
    check("stuck_dst", 2, dst_v[2], 2);
    check("stuck_dat", 2, dat_v[2], 14);
    check("stuck_red", 2, red_v[2], 3);
    #2;
    resp_on[2] = 1'b1;

    // Free-running traffic on A
    wait_seen(0, 6, 2000);
    wait_seen(1, 3, 2000);

    // Reset A while channel 0 is in REQ
    wait_req(0, 200);
    mon_on[0] = 1'b0; mon_on[1] = 1'b0;
    resp_on[0] = 1'b0; resp_on[1] = 1'b0;
    #2;
    rst_a = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      check("midrst_req", c, req_v[c], 0);
      check("midrst_busy", c, busy_v[c], 0);
      check("midrst_sent", c, sent_v[c], 0);
      check("midrst_dst", c, dst_v[c], 1);
      check("midrst_dat", c, dat_v[c], c_init(c));
    end
    ack_all[1:0] = 2'b00;
    for (int c = 0; c < 2; c++) begin
      exp_q[c].delete();
      nxt_idx[c] = 0; ack_cnt[c] = 0; dly[c] = 0; in_pkt[c] = 1'b0;
      push_next(c);
    end
    @(negedge clk);
    #2;
    mon_on[0] = 1'b1; mon_on[1] = 1'b1;
    resp_on[0] = 1'b1; resp_on[1] = 1'b1;
    rst_a = 1'b1;
    s0 = seen[0];
    wait_seen(0, s0 + 4, 2000);

    // Drop enable while channel 0 is in REQ: packet completes, nothing new loads
    wait_req(0, 200);
    #2;
    en_a = 1'b0;
    n = 0;
    while (busy_v[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy_v[0]) fail_now("en_drain", 0);
    s0 = seen[0];
    repeat (30) @(negedge clk);
    check("en_off_busy", 0, busy_v[0], 0);
    check("en_off_req", 0, req_v[0], 0);
    check("en_off_seen", 0, seen[0], s0);
    check("en_off_sent", 0, sent_v[0], ack_cnt[0]);
    #2;
    en_a = 1'b1;
    wait_seen(0, s0 + 3, 2000);

    // Packet limit on B
    n = 0;
    while (!done_v[2] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!done_v[2]) fail_now("wait_done", 2);
    repeat (50) @(negedge clk);
    check("lim_done", 2, done_v[2], 1);
    check("lim_sent", 2, sent_v[2], 3);
    check("lim_pkts", 2, seen[2], 3);
    check("lim_req", 2, req_v[2], 0);
    check("lim_busy", 2, busy_v[2], 0);
    check("lim_pending", 2, exp_q[2].size(), 0);
    check("ch1_progress", 1, (seen[1] >= 3) ? 1 : 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
